// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake between the register/config logic and clk_div_ctrl.
// The master offers a divide value; the slave signals when it can take one.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Run/stop and reconfiguration controller for the clock divider: owns the divide
// counter and clk_d, stops glitch-free and swaps divide values only at terminal count.
module clk_div_ctrl #(
  parameter int          CNT_W   = 16,
  parameter int unsigned DIV_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  clk_div_ctrl_if.slave    cfg,
  input  logic             run_req,
  output logic             clk_d,
  output logic             tick,
  output logic             active,
  output logic [CNT_W-1:0] div_cur
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pend_div;
  logic             pend_valid;
  logic             terminal;
  logic             xfer;

  // Compare before increment so div_cur = all-ones never needs a wider counter.
  always_comb begin
    terminal = (count == div_cur);
    xfer     = cfg.cfg_valid && !pend_valid;
  end

  assign cfg.cfg_ready = ~pend_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      clk_d      <= 1'b0;
      tick       <= 1'b0;
      active     <= 1'b0;
      div_cur    <= CNT_W'(DIV_RST);
      pend_div   <= '0;
      pend_valid <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          clk_d <= 1'b0;
          if (xfer) div_cur <= cfg.cfg_div;
          if (run_req) begin
            state  <= RUN;
            active <= 1'b1;
          end
        end

        RUN, DRAIN: begin
          if (terminal) begin
            count <= '0;
            clk_d <= ~clk_d;
            tick  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end

          // A value accepted on a terminal edge waits for the next one.
          if (xfer) begin
            pend_div   <= cfg.cfg_div;
            pend_valid <= 1'b1;
          end
          if (terminal && pend_valid) begin
            div_cur    <= pend_div;
            pend_valid <= 1'b0;
          end

          if (state == RUN) begin
            if (!run_req) state <= DRAIN;
          end else if (run_req) begin
            state <= RUN;
          end else if (!clk_d || terminal) begin
            // Stop only from the low phase, or on the edge that ends the high phase.
            state      <= IDLE;
            active     <= 1'b0;
            count      <= '0;
            pend_valid <= 1'b0;
            if (!clk_d) begin
              clk_d <= 1'b0;
              tick  <= 1'b0;
            end
            if (xfer) div_cur <= cfg.cfg_div;
            else if (pend_valid) div_cur <= pend_div;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomised scoreboard bench for clk_div_ctrl: a half-period countdown model
// predicts every cycle's outputs and a monitor compares them on the falling edge.
module tb_clk_div_ctrl;

  localparam int CNT_W   = 16;
  localparam int DIV_RST = 1;

  typedef struct {
    bit clk_d;
    bit tick;
    bit active;
    bit ready;
    int div;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_req;
  logic             clk_d;
  logic             tick;
  logic             active;
  logic [CNT_W-1:0] div_cur;

  clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_div_ctrl #(.CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg_if),
    .run_req (run_req),
    .clk_d   (clk_d),
    .tick    (tick),
    .active  (active),
    .div_cur (div_cur)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model: running flag, stop-request flag, edges left in the half-period.
  bit   m_on, m_drain, m_clk, m_tick, m_acc;
  int   m_left, m_div;
  int   m_pend[$];

  task automatic modelStep(input bit r, input bit run, input bit v, input int d);
    bit had_pend;
    int pv;
    bit stop_now;
    m_acc = 1'b0;
    if (r) begin
      m_on = 0; m_drain = 0; m_clk = 0; m_tick = 0; m_div = DIV_RST; m_pend.delete();
    end else if (!m_on) begin
      m_clk  = 0;
      m_tick = 0;
      m_acc  = v;
      if (v) m_div = d;
      if (run) begin
        m_on = 1; m_drain = 0; m_left = m_div + 1;
      end
    end else begin
      m_acc    = v && (m_pend.size() == 0);
      had_pend = (m_pend.size() != 0);
      pv       = had_pend ? m_pend[0] : 0;
      stop_now = m_drain && !run;
      if (stop_now && !m_clk) begin
        m_on = 0; m_tick = 0;
        if (m_acc) m_div = d;
        else if (had_pend) m_div = pv;
        m_pend.delete();
      end else begin
        m_tick = 0;
        m_left--;
        if (m_left == 0) begin
          m_clk  = !m_clk;
          m_tick = 1;
          if (had_pend) begin
            m_div = pv;
            void'(m_pend.pop_front());
          end
          m_left = m_div + 1;
        end
        if (m_acc) m_pend.push_back(d);
        if (stop_now && m_tick) begin
          m_on = 0;
          if (m_pend.size() != 0) m_div = m_pend[0];
          m_pend.delete();
        end
      end
      m_drain = m_on && !run;
    end
  endtask

  // Drive inputs, let the edge happen, then queue what the model expects after it.
  task automatic applyStimulus(input bit r, input bit run, input bit v, input int d);
    exp_t e;
    rst              = r;
    run_req          = run;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = CNT_W'(d);
    @(posedge clk);
    modelStep(r, run, v, d);
    e.clk_d  = m_clk;
    e.tick   = m_tick;
    e.active = m_on;
    e.ready  = (m_pend.size() == 0);
    e.div    = m_div;
    sb.push_back(e);
    #1;
  endtask

  task automatic cmp(input string name, input int got, input int want);
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    cmp("clk_d", int'(clk_d), int'(e.clk_d));
    cmp("tick", int'(tick), int'(e.tick));
    cmp("active", int'(active), int'(e.active));
    cmp("cfg_ready", int'(cfg_if.cfg_ready), int'(e.ready));
    cmp("div_cur", int'(div_cur), e.div);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic runUntilClk(input bit level, input bit run);
    for (int i = 0; i < 40 && m_clk != level; i++) applyStimulus(0, run, 0, 0);
  endtask

  initial begin
    bit run_r, hold;
    int hdiv;
    rst = 1'b1; run_req = 1'b0; cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = '0;
    #1;

    repeat (3) applyStimulus(1, 0, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 0);

    // Run at div 1, then reconfigure to 3 mid-period.
    repeat (9) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 3);
    repeat (20) applyStimulus(0, 1, 0, 0);

    // Stop one cycle after a rising edge: high phase must complete.
    runUntilClk(0, 1);
    runUntilClk(1, 1);
    applyStimulus(0, 1, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 0);

    // One-cycle stop blip while high, then continue.
    runUntilClk(1, 1);
    applyStimulus(0, 0, 0, 0);
    repeat (12) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 40 && m_on; i++) applyStimulus(0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);

    // div 0: clk_d toggles every cycle, tick stays high.
    applyStimulus(0, 0, 1, 0);
    repeat (8) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 40 && m_on; i++) applyStimulus(0, 0, 0, 0);

    // Reset while a config is pending.
    applyStimulus(0, 0, 1, 4);
    repeat (3) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 2);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    repeat (12) applyStimulus(0, 1, 0, 0);

    // Random traffic; the requester holds cfg_valid until the model accepts it.
    run_r = 1; hold = 0; hdiv = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) run_r = !run_r;
      if (!hold && $urandom_range(0, 7) == 0) begin
        hold = 1;
        hdiv = $urandom_range(0, 4);
      end
      applyStimulus($urandom_range(0, 299) == 0, run_r, hold, hdiv);
      if (m_acc) hold = 0;
    end
    applyStimulus(0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d queued, expected 0", sb.size());
    end
    if (vectors == 0) begin
      miscompares++;
      $display("[TB] FAIL vectors: got 0, expected nonzero");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run/stop and reconfiguration controller for the clock divider. It owns the divide counter and the divided clock, and starts and stops the output glitch-free. It accepts new divide values through a valid/ready handshake and applies them only at a terminal-count boundary, so that no half-period on clk_d is ever truncated. It sits between the register/config logic and every consumer of the divided clock and its tick strobe.

Parameters:
CNT_W, 16, width of the divide value and the internal counter.
DIV_RST, 1, divide value loaded at reset.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
cfg_valid  in  1  a new divide value is offered.
cfg_div  in  CNT_W  the offered divide value.
cfg_ready  out  1  the controller can accept cfg_div.
run_req  in  1  level request: 1 = run the divider, 0 = stop it.
clk_d  out  1  divided clock (registered).
tick  out  1  one-cycle strobe, high in every cycle in which clk_d has just toggled.
active  out  1  high in RUN and DRAIN.
div_cur  out  CNT_W  divide value currently in effect.

Behaviour:
- Divide law: while running, count goes 0..div_cur. The edge that samples count==div_cur wraps count to 0, toggles clk_d and sets tick for the following cycle. clk_d period = 2*(div_cur+1) clk cycles. div_cur=0 gives period 2.
- Reset (rst=1 at an edge):
  - state=IDLE, count=0, clk_d=0, tick=0, active=0.
  - div_cur=DIV_RST, pending flag cleared, cfg_ready=1.
  - rst takes priority over every other input, including in the middle of RUN or DRAIN, and any pending config is discarded.
- States:
  - IDLE: count held at 0, clk_d=0.
    - run_req=1 sampled -> RUN. active=1 and count=0 after that edge.
    - The first toggle of clk_d (to 1) occurs div_cur+1 edges later.
  - RUN: counting per the divide law.
    - run_req=0 sampled -> DRAIN. Counting continues on that same edge.
  - DRAIN:
    - If clk_d=0 at the sampling edge: -> IDLE and count=0.
    - If clk_d=1: keep counting; the terminal edge that drives clk_d to 0 also moves to IDLE and sets count=0.
    - run_req=1 sampled in DRAIN -> RUN with no disturbance to count or clk_d.
    - A stop request never shortens a high phase, and the low phase is not stretched beyond the first edge.
- Config handshake: a transfer occurs on an edge where cfg_valid & cfg_ready.
  - In IDLE: div_cur=cfg_div after that edge. cfg_ready stays 1.
  - In RUN or DRAIN: the value is latched as pending and cfg_ready=0.
    - The next terminal edge wraps count using the old div_cur and loads div_cur from pending.
    - The pending flag clears and cfg_ready=1 from that edge on.
    - A transfer on the same edge as a terminal count is held pending until the following terminal edge.
  - Pending value plus a DRAIN->IDLE transition: pending is applied on the transition edge.
  - cfg_valid while cfg_ready=0 is ignored. The requester must hold it.
- tick is 0 in IDLE and is never high for two consecutive cycles unless div_cur=0.
- Widths: count and div_cur are CNT_W bits. div_cur = 2^CNT_W-1 must work without overflow: the compare happens before the increment.

Test Plan:
- Reset and idle: hold rst 3 cycles, then idle 10 cycles -> clk_d=0, tick=0, active=0, div_cur=1, cfg_ready=1 throughout.
- Basic run, div_cur=1: raise run_req at edge E0 -> clk_d rises after E2, falls after E4, period 4; tick high only in the cycles after E2, E4, E6, and so on.
- Reconfig while running: running at div=1, write cfg_div=3 mid-period -> cfg_ready drops. The current half-period still lasts 2 cycles. Subsequent half-periods last 4 cycles, div_cur=3 from the load edge, and cfg_ready returns to 1.
- Stop while clk_d is high: div=3, drop run_req one cycle after clk_d rises -> clk_d stays high for the full 4 cycles, then goes 0. active drops on the same edge; count=0.
- Stop/restart in DRAIN and div_cur=0: drop run_req for 1 cycle while clk_d=1 -> output is indistinguishable from continuous RUN. Then configure div=0 in IDLE and run -> clk_d toggles every cycle and tick stays high continuously.
- Reset mid-operation: assert rst while a config is pending in RUN -> the next cycle shows IDLE outputs, div_cur=DIV_RST, cfg_ready=1, and the pending value is never applied.
